// File: rtl/mux_n_to_1_rr.sv
// rtl/mux_n_to_1_rr.sv - registered N-to-1 valid/ready mux, fixed-select or round-robin grant
// Optional MUX_COUNT_EN adds a 16-bit xfer_count of output transfers.
module mux_n_to_1_rr #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int SELW    = $clog2(CHANNELS)
) (
  input  logic                      Clock,
  input  logic                      Resetn,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SELW-1:0]           S,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef MUX_COUNT_EN
  ,
  output logic [15:0]               xfer_count
`endif
);

  logic [WIDTH-1:0] chan_data [CHANNELS];
  logic             load;
  logic             grant_valid;
  logic [SELW-1:0]  grant_idx;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_chan_q, out_chan_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
    assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  assign load = !out_valid_q || out_ready;

  // Round-robin scan runs from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    int              idx;
    logic [SELW-1:0] idx_sel;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    idx_sel     = '0;
    if (mode) begin
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        idx = int'(ptr_q) + k;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        idx_sel = SELW'(idx);
        if (in_valid[idx_sel]) begin
          grant_valid = 1'b1;
          grant_idx   = idx_sel;
        end
      end
    end else if (int'(S) < CHANNELS) begin
      if (in_valid[S]) begin
        grant_valid = 1'b1;
        grant_idx   = S;
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (Resetn && load && grant_valid) in_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (load && grant_valid) begin
      out_valid_d = 1'b1;
      out_data_d  = chan_data[grant_idx];
      out_chan_d  = grant_idx;
      if (mode) ptr_d = (int'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + SELW'(1);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

`ifdef MUX_COUNT_EN
  logic [15:0] count_q, count_d;

  assign count_d = (out_valid_q && out_ready) ? count_q + 16'd1 : count_q;

  always_ff @(posedge Clock) begin
    if (!Resetn) count_q <= '0;
    else         count_q <= count_d;
  end

  assign xfer_count = count_q;
`endif

endmodule
